dma_ctrl: RTL and testbench

- CPU-programmable memory-to-memory DMA engine for the 6502 SoC.
- Sits on the CPU bus as a peripheral (own chip select, 8 byte-wide registers).
- When started, it stalls the CPU through RDY, takes ownership of the address/data bus via a top-level mux, and copies a block of bytes.
- It then releases the bus and optionally raises IRQ.

---
 rtl/dma_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// rtl/dma_ctrl.sv - CPU-programmable memory-to-memory DMA engine
//
// Stalls the CPU through cpu_rdy, owns the bus while copying LEN bytes
// from SRC to DST (2 clocks per byte), then releases the bus and flags
// DONE, optionally raising irq.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   cs, we, rs, din    CPU register interface (8 byte-wide registers)
//   dout               registered register read data
//   dma_req            high while the engine owns the bus
//   dma_ab/do/we       DMA address, write data, write strobe
//   dma_di             read data, one-clock synchronous latency
//   cpu_rdy            low stalls the CPU
//   irq                DONE & IE, level, active high
module dma_ctrl #(
  parameter int ARB_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dma_req,
  output logic [15:0] dma_ab,
  output logic [7:0]  dma_do,
  output logic        dma_we,
  input  logic [7:0]  dma_di,
  output logic        cpu_rdy,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_WR, S_FIN} state_t;

  localparam logic [1:0] ARB_LAST = 2'(ARB_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  arb_cnt_q, arb_cnt_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        ie_q, ie_d;
  logic        src_fix_q, src_fix_d;
  logic        dst_fix_q, dst_fix_d;
  logic        done_q, done_d;
  logic [7:0]  dout_q, dout_d;

  logic        reg_wr;
  logic        busy;
  logic [7:0]  status;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      arb_cnt_q <= 2'd0;
      src_q     <= 16'h0000;
      dst_q     <= 16'h0000;
      len_q     <= 16'h0000;
      ie_q      <= 1'b0;
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      arb_cnt_q <= arb_cnt_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      ie_q      <= ie_d;
      src_fix_q <= src_fix_d;
      dst_fix_q <= dst_fix_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arb_cnt_d = arb_cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    ie_d      = ie_q;
    src_fix_d = src_fix_q;
    dst_fix_d = dst_fix_q;
    done_d    = done_q;

    reg_wr = cs & we;
    busy   = (state_q == S_ARB) || (state_q == S_RD) || (state_q == S_WR);
    status = {busy, done_q, 2'b00, dst_fix_q, src_fix_q, ie_q, 1'b0};

    case (rs)
      3'd0:    dout_d = src_q[7:0];
      3'd1:    dout_d = src_q[15:8];
      3'd2:    dout_d = dst_q[7:0];
      3'd3:    dout_d = dst_q[15:8];
      3'd4:    dout_d = len_q[7:0];
      3'd5:    dout_d = len_q[15:8];
      3'd6:    dout_d = status;
      default: dout_d = 8'h00;
    endcase

    // DONE clear is honoured in any state; FIN below overrides it.
    if (reg_wr && rs == 3'd7) done_d = 1'b0;

    // All other writes only land while idle (FIN included in the block).
    if (reg_wr && state_q == S_IDLE) begin
      case (rs)
        3'd0: src_d[7:0]  = din;
        3'd1: src_d[15:8] = din;
        3'd2: dst_d[7:0]  = din;
        3'd3: dst_d[15:8] = din;
        3'd4: len_d[7:0]  = din;
        3'd5: len_d[15:8] = din;
        3'd6: begin
          ie_d      = din[1];
          src_fix_d = din[2];
          dst_fix_d = din[3];
          if (din[0]) begin
            if (len_q == 16'h0000) begin
              done_d = 1'b1;
            end else begin
              state_d   = S_ARB;
              arb_cnt_d = 2'd0;
              done_d    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_ARB: begin
        if (arb_cnt_q == ARB_LAST) state_d = S_RD;
        else arb_cnt_d = arb_cnt_q + 2'd1;
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        len_d = len_q - 16'd1;
        if (!src_fix_q) src_d = src_q + 16'd1;
        if (!dst_fix_q) dst_d = dst_q + 16'd1;
        state_d = (len_q == 16'd1) ? S_FIN : S_RD;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  // Bus outputs decode straight from the (asynchronously reset) state so
  // a reset releases the bus and the CPU without waiting for a clock.
  // cpu_rdy stays low through FIN, giving ARB_CYCLES + 2*LEN + 1 stall clocks.
  assign cpu_rdy = (state_q == S_IDLE);
  assign dma_req = (state_q == S_RD) || (state_q == S_WR);
  assign dma_we  = (state_q == S_WR);
  assign dma_ab  = (state_q == S_RD) ? src_q : (state_q == S_WR) ? dst_q : 16'h0000;
  assign dma_do  = (state_q == S_WR) ? dma_di : 8'h00;
  assign irq     = done_q & ie_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb/tb_dma_ctrl.sv - scoreboard testbench for dma_ctrl
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, we;
  logic [2:0]  rs;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dma_req;
  logic [15:0] dma_ab;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic [7:0]  dma_di;
  logic        cpu_rdy;
  logic        irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  logic        sb_en;
  int          stall_cnt;
  logic        req_seen;
  logic        irq_seen;

  localparam logic [7:0] PAT [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  dma_ctrl #(.ARB_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din),
    .dout(dout), .dma_req(dma_req), .dma_ab(dma_ab), .dma_do(dma_do),
    .dma_we(dma_we), .dma_di(dma_di), .cpu_rdy(cpu_rdy), .irq(irq)
  );

  // Memory with one-clock read latency; 0x2000 models an ACIA data register.
  always @(posedge clk) begin
    if (dma_we) mem[dma_ab] <= dma_do;
    else if (bd_we) mem[bd_addr] <= bd_data;
    rd_q <= (dma_ab == 16'h2000) ? 8'h5A : mem[dma_ab];
  end
  assign dma_di = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!cpu_rdy) stall_cnt++;
    if (dma_req) req_seen = 1'b1;
    if (irq) irq_seen = 1'b1;
    if (sb_en && dma_we) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_wr", {16'h0, dma_ab}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_addr", {16'h0, dma_ab}, {16'h0, e.a});
        check("sb_data", {24'h0, dma_do}, {24'h0, e.d});
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] r, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = r; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] r, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; rs = r;
    @(posedge clk); #1;
    d = dout;
    cs = 1'b0;
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
    cpu_write(3'd0, s[7:0]);
    cpu_write(3'd1, s[15:8]);
    cpu_write(3'd2, dd[7:0]);
    cpu_write(3'd3, dd[15:8]);
    cpu_write(3'd4, l[7:0]);
    cpu_write(3'd5, l[15:8]);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (cpu_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'h0, ok}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    reset = 1'b1; cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00;
    bd_we = 1'b0; bd_addr = 16'h0; bd_data = 8'h0;
    sb_en = 1'b1; stall_cnt = 0; req_seen = 1'b0; irq_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_req", {31'h0, dma_req}, 32'h0);
    check("rst_ab", {16'h0, dma_ab}, 32'h0);
    check("rst_do", {24'h0, dma_do}, 32'h0);
    check("rst_we", {31'h0, dma_we}, 32'h0);
    check("rst_rdy", {31'h0, cpu_rdy}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Basic copy with IE.
    for (int i = 0; i < 4; i++) bd_write(16'h0100 + 16'(i), PAT[i]);
    setup(16'h0100, 16'h0200, 16'd4);
    for (int i = 0; i < 4; i++) push_exp(16'h0200 + 16'(i), PAT[i]);
    stall_cnt = 0;
    cpu_write(3'd6, 8'h03);
    wait_done("basic_end");
    check("basic_stall", stall_cnt, 32'd10);
    check("basic_sb_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 4; i++) check("basic_mem", {24'h0, mem[16'h0200 + 16'(i)]}, {24'h0, PAT[i]});
    cpu_read(3'd6, rd); check("basic_status", {24'h0, rd}, 32'h42);
    check("basic_irq", {31'h0, irq}, 32'h1);
    cpu_read(3'd4, rd); check("basic_len", {24'h0, rd}, 32'h00);
    cpu_read(3'd0, rd); check("basic_src_lo", {24'h0, rd}, 32'h04);
    cpu_read(3'd2, rd); check("basic_dst_lo", {24'h0, rd}, 32'h04);
    cpu_write(3'd7, 8'h00);
    check("clr_irq", {31'h0, irq}, 32'h0);
    cpu_read(3'd6, rd); check("clr_status", {24'h0, rd}, 32'h02);
    cpu_read(3'd7, rd); check("reg7_read", {24'h0, rd}, 32'h00);

    // Fixed-source fill from the ACIA model.
    setup(16'h2000, 16'h0300, 16'd3);
    for (int i = 0; i < 3; i++) push_exp(16'h0300 + 16'(i), 8'h5A);
    cpu_write(3'd6, 8'h05);
    wait_done("fill_end");
    check("fill_sb_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 3; i++) check("fill_mem", {24'h0, mem[16'h0300 + 16'(i)]}, 32'h5A);
    cpu_read(3'd0, rd); check("fill_src_lo", {24'h0, rd}, 32'h00);
    cpu_read(3'd1, rd); check("fill_src_hi", {24'h0, rd}, 32'h20);
    cpu_read(3'd2, rd); check("fill_dst_lo", {24'h0, rd}, 32'h03);
    cpu_read(3'd3, rd); check("fill_dst_hi", {24'h0, rd}, 32'h03);

    // Zero length.
    cpu_write(3'd7, 8'h00);
    cpu_write(3'd4, 8'h00);
    stall_cnt = 0; req_seen = 1'b0;
    cpu_write(3'd6, 8'h01);
    cpu_read(3'd6, rd); check("zero_status", {24'h0, rd}, 32'h40);
    repeat (3) @(posedge clk);
    #1;
    check("zero_req", {31'h0, req_seen}, 32'h0);
    check("zero_stall", stall_cnt, 32'd0);

    // Destination wrap-around.
    setup(16'h0100, 16'hFFFF, 16'd2);
    push_exp(16'hFFFF, PAT[0]);
    push_exp(16'h0000, PAT[1]);
    cpu_write(3'd6, 8'h01);
    wait_done("wrap_end");
    check("wrap_sb_empty", exp_q.size(), 32'd0);
    check("wrap_mem_ffff", {24'h0, mem[16'hFFFF]}, {24'h0, PAT[0]});
    check("wrap_mem_0000", {24'h0, mem[16'h0000]}, {24'h0, PAT[1]});
    cpu_read(3'd2, rd); check("wrap_dst_lo", {24'h0, rd}, 32'h01);
    cpu_read(3'd3, rd); check("wrap_dst_hi", {24'h0, rd}, 32'h00);

    // Busy protection, IE off: LEN write during ARB is ignored.
    cpu_write(3'd7, 8'h00);
    setup(16'h0100, 16'h0400, 16'd2);
    push_exp(16'h0400, PAT[0]);
    push_exp(16'h0401, PAT[1]);
    stall_cnt = 0; irq_seen = 1'b0;
    cpu_write(3'd6, 8'h01);
    cpu_write(3'd4, 8'h55);
    wait_done("busy_end");
    check("busy_stall", stall_cnt, 32'd6);
    check("busy_sb_empty", exp_q.size(), 32'd0);
    cpu_read(3'd4, rd); check("busy_len", {24'h0, rd}, 32'h00);
    cpu_read(3'd6, rd); check("busy_status", {24'h0, rd}, 32'h40);
    check("busy_irq_never", {31'h0, irq_seen}, 32'h0);

    // Reset mid-transfer.
    sb_en = 1'b0;
    cpu_write(3'd6, 8'h02);
    setup(16'h0100, 16'h0500, 16'h0100);
    cpu_write(3'd6, 8'h03);
    repeat (20) @(posedge clk);
    @(negedge clk); #2;
    check("mid_req_before", {31'h0, dma_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rdy_async", {31'h0, cpu_rdy}, 32'h1);
    check("mid_req_async", {31'h0, dma_req}, 32'h0);
    check("mid_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      cpu_read(3'(r), rd);
      check("mid_reg_zero", {24'h0, rd}, 32'h0);
    end
    check("mid_rdy_after", {31'h0, cpu_rdy}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
